// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: initiator-side controller for a word-wide data memory.
// Accepts byte/half/word loads and stores, performs read-modify-write for
// sub-word stores, and returns extended load data with a one-cycle strobe.
module mem_access_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reqValid,
    output logic              reqReady,
    input  logic              reqWrite,
    input  logic [1:0]        reqSize,
    input  logic              reqSigned,
    input  logic [31:0]       reqAddr,
    input  logic [DATA_W-1:0] reqWData,
    output logic              rspValid,
    output logic [DATA_W-1:0] rspRData,
    output logic              rspError,
    output logic [ADDR_W-1:0] memAddress,
    output logic [DATA_W-1:0] memWrData,
    output logic              memRead,
    output logic              memWrite,
    input  logic [DATA_W-1:0] memRdData
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_READ    = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_WRITE   = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              write_q, write_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic [1:0]        lane_q, lane_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;   // store data, later the merged word
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              req_err;
    logic [4:0]        shamt;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [DATA_W-1:0] ext_data;
    logic [DATA_W-1:0] lane_mask;
    logic [DATA_W-1:0] merged;

    // Classify an incoming request as illegal size, misaligned or out of range
    always_comb begin
        req_err = (reqSize == 2'd3)
               || (reqSize == 2'd1 && reqAddr[0])
               || (reqSize == 2'd2 && reqAddr[1:0] != 2'b00)
               || (|reqAddr[31:ADDR_W+2]);
    end

    // Lane extraction/extension for loads and lane merge for sub-word stores
    always_comb begin
        shamt  = {lane_q, 3'b000};
        lane_b = memRdData[shamt +: 8];
        lane_h = memRdData[{lane_q[1], 4'b0000} +: 16];
        case (size_q)
            2'd0:    ext_data = {{(DATA_W-8){signed_q & lane_b[7]}}, lane_b};
            2'd1:    ext_data = {{(DATA_W-16){signed_q & lane_h[15]}}, lane_h};
            default: ext_data = memRdData;
        endcase
        if (size_q == 2'd0)
            lane_mask = {{(DATA_W-8){1'b0}}, 8'hFF} << shamt;
        else
            lane_mask = {{(DATA_W-16){1'b0}}, 16'hFFFF} << shamt;
        merged = (memRdData & ~lane_mask) | ((wdata_q << shamt) & lane_mask);
    end

    // Next-state and request latch logic
    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        size_d   = size_q;
        signed_d = signed_q;
        lane_d   = lane_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (reqValid) begin
                    write_d  = reqWrite;
                    size_d   = reqSize;
                    signed_d = reqSigned;
                    lane_d   = reqAddr[1:0];
                    addr_d   = reqAddr[ADDR_W+1:2];
                    wdata_d  = reqWData;
                    rdata_d  = '0;
                    err_d    = req_err;
                    if (req_err)
                        state_d = S_RESP;
                    else if (reqWrite && reqSize == 2'd2)
                        state_d = S_WRITE;
                    else
                        state_d = S_READ;
                end
            end
            S_READ:    state_d = S_CAPTURE;
            S_CAPTURE: begin
                if (write_q) begin
                    wdata_d = merged;
                    state_d = S_WRITE;
                end else begin
                    rdata_d = ext_data;
                    state_d = S_RESP;
                end
            end
            S_WRITE:   state_d = S_RESP;
            S_RESP:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // State and latched request registers; reset aborts any operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            write_q  <= 1'b0;
            size_q   <= 2'd0;
            signed_q <= 1'b0;
            lane_q   <= 2'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            lane_q   <= lane_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Outputs decode from state so reset clears them without waiting for a clock
    always_comb begin
        reqReady   = (state_q == S_IDLE);
        memRead    = (state_q == S_READ) || (state_q == S_CAPTURE);
        memWrite   = (state_q == S_WRITE);
        memAddress = addr_q;
        memWrData  = (state_q == S_WRITE) ? wdata_q : '0;
        rspValid   = (state_q == S_RESP);
        rspError   = (state_q == S_RESP) && err_q;
        rspRData   = (state_q == S_RESP) ? rdata_q : '0;
    end

endmodule
